fwd_hazard_unit: RTL and testbench

- Parametrised successor to the combinational EX-stage forwarding logic. Adds internal tracking of in-flight destination registers, load-use stall and bubble generation, and forwarding from a configurable number of downstream stages.
- Sits beside the ID/EX pipeline register. It consumes ID-stage decode fields and drives the EX operand-mux selects and the IF/ID hold/bubble controls.

---
 rtl/fwd_hazard_unit.sv | 113 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding and load-use hazard unit with an in-flight destination tag pipeline.
// Optional stall counter (stall_cnt, cnt_clr) is built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  localparam int SELW     = ($clog2(FWD_DEPTH + 1) > 1) ? $clog2(FWD_DEPTH + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall_o,
  output logic              bubble_o,
`ifdef FWD_HAZARD_PERF_EN
  input  logic              cnt_clr,
  output logic [31:0]       stall_cnt,
`endif
  output logic [SELW-1:0]   fwd_a,
  output logic [SELW-1:0]   fwd_b
);

  typedef struct packed {
    logic              v;
    logic              wr;
    logic              ld;
    logic [REG_AW-1:0] dest;
  } tag_t;

  // Entry 0 is the instruction in EX; entry k is post-EX stage k.
  tag_t              tags [FWD_DEPTH+1];
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;

  logic haz_rs;
  logic haz_rt;
  logic issue;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    // Only loads younger than LOAD_LAT are still unable to forward their data.
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (tags[j].v && tags[j].ld && tags[j].wr) begin
        if (tags[j].dest == id_rs) haz_rs = 1'b1;
        if (tags[j].dest == id_rt) haz_rt = 1'b1;
      end
    end
    haz_rs = haz_rs && id_use_rs && id_valid && (id_rs != '0);
    haz_rt = haz_rt && id_use_rt && id_valid && (id_rt != '0);
  end

  assign stall_o  = (haz_rs || haz_rt) && !flush;
  assign bubble_o = stall_o || flush;
  assign issue    = id_valid && !stall_o && !flush;

  // Walk from the oldest stage to the youngest so the lowest k is the last writer.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (tags[k].v && tags[k].wr && (!tags[k].ld || (k > LOAD_LAT))) begin
        if ((ex_rs != '0) && (tags[k].dest == ex_rs)) fwd_a = SELW'(k);
        if ((ex_rt != '0) && (tags[k].dest == ex_rt)) fwd_b = SELW'(k);
      end
    end
  end

  // NOTE: the tag array is control state, not storage; every entry is reset so
  // no stale valid bit can raise a hazard or a forward after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= FWD_DEPTH; k++) tags[k] <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
    end else begin
      // NOTE: non-blocking assignments let each entry take the previous
      // entry's old value, giving a true shift register regardless of order.
      for (int k = 1; k <= FWD_DEPTH; k++) tags[k] <= tags[k-1];
      if (issue) begin
        tags[0] <= '{v: 1'b1, wr: id_regwrite, ld: id_memread, dest: id_dest};
        ex_rs   <= id_rs;
        ex_rt   <= id_rt;
      end else begin
        tags[0] <= '0;
        ex_rs   <= '0;
        ex_rt   <= '0;
      end
    end
  end

`ifdef FWD_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_o && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default instance (2/1) and deep instance (FWD_DEPTH=3, LOAD_LAT=2)
// driven by the same ID stream and checked against an instruction-history model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, flush;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       stall0, bubble0, stall1, bubble1;
  logic [1:0] fa0, fb0, fa1, fb1;
`ifdef FWD_HAZARD_PERF_EN
  logic        cnt_clr;
  logic        clr_req;
  logic [31:0] cnt0, cnt1;
  int unsigned mcnt [2];
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall_o(stall0), .bubble_o(bubble0),
`ifdef FWD_HAZARD_PERF_EN
    .cnt_clr(cnt_clr), .stall_cnt(cnt0),
`endif
    .fwd_a(fa0), .fwd_b(fb0)
  );

  fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall_o(stall1), .bubble_o(bubble1),
`ifdef FWD_HAZARD_PERF_EN
    .cnt_clr(cnt_clr), .stall_cnt(cnt1),
`endif
    .fwd_a(fa1), .fwd_b(fb1)
  );

  // History of issued instructions per instance: index 0 = in EX, k = k stages later.
  typedef struct packed {
    logic       v, wr, ld;
    logic [4:0] dest, rs, rt;
  } instr_t;

  instr_t     hist [2][4];
  logic [5:0] e_vec [2];
  int         checks, errors;

  function automatic int depth_of(int m);
    return (m == 0) ? 2 : 3;
  endfunction

  function automatic int lat_of(int m);
    return (m == 0) ? 1 : 2;
  endfunction

  // A load issued fewer than LOAD_LAT cycles ago cannot yet supply register s.
  function automatic logic load_pending(int m, logic [4:0] s);
    for (int j = 0; j < lat_of(m); j++)
      if (hist[m][j].v && hist[m][j].ld && hist[m][j].wr && hist[m][j].dest == s) return 1'b1;
    return 1'b0;
  endfunction

  // Nearest older writer of s whose data is available; 0 means register file.
  function automatic logic [1:0] src_of(int m, logic [4:0] s);
    if (s == 5'd0) return 2'd0;
    for (int k = 1; k <= depth_of(m); k++)
      if (hist[m][k].v && hist[m][k].wr && hist[m][k].dest == s && (!hist[m][k].ld || k > lat_of(m)))
        return 2'(k);
    return 2'd0;
  endfunction

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) hist[m][k] = '0;
`ifdef FWD_HAZARD_PERF_EN
      mcnt[m] = 0;
`endif
    end
  endtask

  // Present one ID-stage instruction, record expected outputs, advance the model.
  task automatic apply(input logic v, input logic [4:0] rs, rt, dest,
                       input logic urs, urt, wr, ld, fl);
    logic st;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_dest = dest;
    id_use_rs = urs; id_use_rt = urt; id_regwrite = wr; id_memread = ld; flush = fl;
`ifdef FWD_HAZARD_PERF_EN
    cnt_clr = clr_req;
`endif
    #1;
    for (int m = 0; m < 2; m++) begin
      st = v && !fl && ((urs && rs != 5'd0 && load_pending(m, rs)) ||
                        (urt && rt != 5'd0 && load_pending(m, rt)));
      e_vec[m] = {st, st || fl, src_of(m, hist[m][0].rs), src_of(m, hist[m][0].rt)};
`ifdef FWD_HAZARD_PERF_EN
      if (clr_req) mcnt[m] = 0;
      else if (st) mcnt[m]++;
`endif
      for (int k = 3; k >= 1; k--) hist[m][k] = hist[m][k-1];
      hist[m][0] = (v && !st && !fl) ? {1'b1, wr, ld, dest, rs, rt} : '0;
    end
  endtask

  task automatic nop();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (4) nop();
  endtask

  task automatic alu(input logic [4:0] rs, rt, dest);
    apply(1'b1, rs, rt, dest, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [4:0] rs, dest);
    apply(1'b1, rs, 5'd0, dest, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({stall0, bubble0, fa0, fb0} !== 6'd0) begin
      errors++; $display("FAIL reset_u0 got %b want 000000", {stall0, bubble0, fa0, fb0});
    end
    checks++;
    if ({stall1, bubble1, fa1, fb1} !== 6'd0) begin
      errors++; $display("FAIL reset_u1 got %b want 000000", {stall1, bubble1, fa1, fb1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_basic();
    drain();
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd3, 5'd4, 5'd6);
    checks++;
    if (stall0 !== 1'b0) begin errors++; $display("FAIL basic_stall got %b want 0", stall0); end
    nop();
    checks++;
    if (fa0 !== 2'd1) begin errors++; $display("FAIL basic_fwd_a got %0d want 1", fa0); end
    checks++;
    if (fb0 !== 2'd0) begin errors++; $display("FAIL basic_fwd_b got %0d want 0", fb0); end
  endtask

  task automatic test_fwd_priority();
    drain();
    alu(5'd1, 5'd2, 5'd3);
    nop();
    alu(5'd5, 5'd3, 5'd7);
    nop();
    checks++;
    if ({fa0, fb0} !== {2'd0, 2'd2}) begin
      errors++; $display("FAIL prio_stage2 got a=%0d b=%0d want a=0 b=2", fa0, fb0);
    end
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd3, 5'd6, 5'd8);
    nop();
    checks++;
    if ({fa0, fb0} !== {2'd1, 2'd0}) begin
      errors++; $display("FAIL prio_youngest got a=%0d b=%0d want a=1 b=0", fa0, fb0);
    end
  endtask

  task automatic test_r0();
    drain();
    alu(5'd1, 5'd2, 5'd0);
    alu(5'd0, 5'd0, 5'd5);
    checks++;
    if (stall0 !== 1'b0) begin errors++; $display("FAIL r0_stall got %b want 0", stall0); end
    nop();
    checks++;
    if ({fa0, fb0} !== 4'd0) begin
      errors++; $display("FAIL r0_fwd got a=%0d b=%0d want 0 0", fa0, fb0);
    end
    load(5'd1, 5'd0);
    alu(5'd0, 5'd0, 5'd5);
    checks++;
    if ({stall0, bubble0} !== 2'b00) begin
      errors++; $display("FAIL r0_load got %b want 00", {stall0, bubble0});
    end
  endtask

  task automatic test_load_use();
    drain();
    load(5'd1, 5'd4);
    alu(5'd4, 5'd2, 5'd6);
    checks++;
    if ({stall0, bubble0} !== 2'b11) begin
      errors++; $display("FAIL lu_stall1 got %b want 11", {stall0, bubble0});
    end
    alu(5'd4, 5'd2, 5'd6);
    checks++;
    if ({stall0, bubble0} !== 2'b00) begin
      errors++; $display("FAIL lu_release got %b want 00", {stall0, bubble0});
    end
    nop();
    checks++;
    if ({fa0, fb0} !== {2'd2, 2'd0}) begin
      errors++; $display("FAIL lu_fwd got a=%0d b=%0d want a=2 b=0", fa0, fb0);
    end
  endtask

  task automatic test_load_use_deep();
    drain();
    load(5'd1, 5'd5);
    alu(5'd5, 5'd2, 5'd6);
    checks++;
    if ({stall1, bubble1} !== 2'b11) begin
      errors++; $display("FAIL deep_stall1 got %b want 11", {stall1, bubble1});
    end
    alu(5'd5, 5'd2, 5'd6);
    checks++;
    if ({stall1, bubble1} !== 2'b11) begin
      errors++; $display("FAIL deep_stall2 got %b want 11", {stall1, bubble1});
    end
    alu(5'd5, 5'd2, 5'd6);
    checks++;
    if (stall1 !== 1'b0) begin errors++; $display("FAIL deep_release got %b want 0", stall1); end
    nop();
    checks++;
    if (fa1 !== 2'd3) begin errors++; $display("FAIL deep_fwd got %0d want 3", fa1); end
  endtask

  task automatic test_flush();
    drain();
    load(5'd1, 5'd4);
    apply(1'b1, 5'd4, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({stall0, bubble0} !== 2'b01) begin
      errors++; $display("FAIL flush_ctl got %b want 01", {stall0, bubble0});
    end
    alu(5'd9, 5'd0, 5'd10);
    nop();
    checks++;
    if (fa0 !== 2'd0) begin errors++; $display("FAIL flush_drop got %0d want 0", fa0); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    load(5'd1, 5'd4);
    alu(5'd4, 5'd2, 5'd6);
    checks++;
    if (stall0 !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %b want 1", stall0); end
    rst_n = 1'b0;
    #1;
    clear_model();
    checks++;
    if ({stall0, bubble0, fa0, fb0} !== 6'd0) begin
      errors++; $display("FAIL rst_mid_u0 got %b want 000000", {stall0, bubble0, fa0, fb0});
    end
    checks++;
    if ({stall1, bubble1, fa1, fb1} !== 6'd0) begin
      errors++; $display("FAIL rst_mid_u1 got %b want 000000", {stall1, bubble1, fa1, fb1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    alu(5'd4, 5'd2, 5'd6);
    checks++;
    if ({stall0, stall1} !== 2'b00) begin
      errors++; $display("FAIL rst_after got %b want 00", {stall0, stall1});
    end
    nop();
    checks++;
    if (fa0 !== 2'd0) begin errors++; $display("FAIL rst_after_fwd got %0d want 0", fa0); end
  endtask

  task automatic test_random();
    logic v, urs, urt, wr, ld, fl;
    logic [4:0] rs, rt, dest;
    drain();
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 9) != 0);
      rs   = 5'($urandom_range(0, 5));
      rt   = 5'($urandom_range(0, 5));
      dest = 5'($urandom_range(0, 5));
      urs  = 1'($urandom_range(0, 1));
      urt  = 1'($urandom_range(0, 1));
      wr   = ($urandom_range(0, 3) != 0);
      ld   = ($urandom_range(0, 2) == 0);
      fl   = ($urandom_range(0, 9) == 0);
      apply(v, rs, rt, dest, urs, urt, wr, ld, fl);
      checks++;
      if ({stall0, bubble0, fa0, fb0} !== e_vec[0]) begin
        errors++;
        $display("FAIL random_u0 iter %0d got %b want %b", i, {stall0, bubble0, fa0, fb0}, e_vec[0]);
      end
      checks++;
      if ({stall1, bubble1, fa1, fb1} !== e_vec[1]) begin
        errors++;
        $display("FAIL random_u1 iter %0d got %b want %b", i, {stall1, bubble1, fa1, fb1}, e_vec[1]);
      end
    end
  endtask

`ifdef FWD_HAZARD_PERF_EN
  task automatic test_perf();
    drain();
    clr_req = 1'b1;
    nop();
    clr_req = 1'b0;
    nop();
    checks++;
    if (cnt0 !== 32'd0) begin errors++; $display("FAIL perf_clr0 got %0d want 0", cnt0); end
    repeat (3) begin
      load(5'd1, 5'd4);
      alu(5'd4, 5'd2, 5'd6);
      alu(5'd4, 5'd2, 5'd6);
    end
    nop();
    checks++;
    if (cnt0 !== 32'd3) begin errors++; $display("FAIL perf_cnt_u0 got %0d want 3", cnt0); end
    checks++;
    if (cnt1 !== 32'(mcnt[1])) begin
      errors++; $display("FAIL perf_cnt_u1 got %0d want %0d", cnt1, mcnt[1]);
    end
    clr_req = 1'b1;
    nop();
    clr_req = 1'b0;
    nop();
    checks++;
    if ({cnt0, cnt1} !== 64'd0) begin
      errors++; $display("FAIL perf_clr got %0d/%0d want 0/0", cnt0, cnt1);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
`ifdef FWD_HAZARD_PERF_EN
    cnt_clr = 1'b0;
    clr_req = 1'b0;
`endif
    clear_model();
    test_reset();
    test_fwd_basic();
    test_fwd_priority();
    test_r0();
    test_load_use();
    test_load_use_deep();
    test_flush();
    test_reset_mid_stall();
    test_random();
`ifdef FWD_HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
